// File: rtl/gpr_port_arbiter.sv
// Shares the single-port GPR file between operand reads (rs1/rs2) and writebacks.
// Writebacks win the port unless a pending read has been starved STARVE_LIMIT times.
module gpr_port_arbiter #(
  parameter int unsigned REG_W        = 32,
  parameter int unsigned SEL_W        = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rd_req_valid,
  output logic             o_rd_req_ready,
  input  logic [SEL_W-1:0] i_rs1,
  input  logic [SEL_W-1:0] i_rs2,
  input  logic             i_need_rs2,
  output logic             o_opnd_valid,
  input  logic             i_opnd_ready,
  output logic [REG_W-1:0] o_rs1_data,
  output logic [REG_W-1:0] o_rs2_data,
  input  logic             i_wb_valid,
  output logic             o_wb_ready,
  input  logic [SEL_W-1:0] i_wb_sel,
  input  logic [REG_W-1:0] i_wb_data,
  output logic [SEL_W-1:0] o_gpr_select,
  output logic             o_gpr_load,
  output logic [REG_W-1:0] o_gpr_wdata,
  input  logic [REG_W-1:0] i_gpr_rdata,
  output logic             o_busy
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, RD1, RD2, HOLD} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] starve_q;
  logic [SEL_W-1:0] rs1_q, rs2_q;
  logic             need_q;
  logic [REG_W-1:0] rs1_data_q, rs2_data_q;

  logic reading;
  logic wb_grant;

  assign reading        = (state_q == RD1) || (state_q == RD2);
  assign o_rd_req_ready = i_rst_n && (state_q == IDLE);
  assign o_wb_ready     = i_rst_n && !(reading && (starve_q == LIMIT_C));
  assign wb_grant       = i_wb_valid && o_wb_ready;
  assign o_opnd_valid   = (state_q == HOLD);
  assign o_busy         = (state_q != IDLE);
  assign o_rs1_data     = rs1_data_q;
  assign o_rs2_data     = rs2_data_q;

  always_comb begin
    o_gpr_select = '0;
    o_gpr_load   = 1'b0;
    o_gpr_wdata  = '0;
    if (wb_grant) begin
      o_gpr_select = i_wb_sel;
      o_gpr_load   = (i_wb_sel != '0);
      o_gpr_wdata  = i_wb_data;
    end else if (state_q == RD1) begin
      o_gpr_select = rs1_q;
    end else if (state_q == RD2) begin
      o_gpr_select = rs2_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      need_q     <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          starve_q <= '0;
          if (i_rd_req_valid) begin
            rs1_q      <= i_rs1;
            rs2_q      <= i_rs2;
            need_q     <= i_need_rs2;
            // x0 and unused rs2 resolve to zero here and never touch the port
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            if (i_rs1 != '0)                      state_q <= RD1;
            else if (i_need_rs2 && i_rs2 != '0)   state_q <= RD2;
            else                                  state_q <= HOLD;
          end
        end
        RD1: begin
          if (wb_grant) begin
            starve_q <= starve_q + 1'b1;
          end else begin
            starve_q   <= '0;
            rs1_data_q <= i_gpr_rdata;
            state_q    <= (need_q && rs2_q != '0) ? RD2 : HOLD;
          end
        end
        RD2: begin
          if (wb_grant) begin
            starve_q <= starve_q + 1'b1;
          end else begin
            starve_q   <= '0;
            rs2_data_q <= i_gpr_rdata;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          starve_q <= '0;
          if (i_opnd_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpr_port_arbiter.sv
// Bench for gpr_port_arbiter: directed scenarios plus a randomized run against
// a queue-based model of the port sharing rules, with a behavioural register file.
module tb_gpr_port_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_req_valid = 1'b0, rd_req_ready;
  logic [4:0]  rs1 = '0, rs2 = '0;
  logic        need_rs2 = 1'b0;
  logic        opnd_valid, opnd_ready = 1'b0;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_valid = 1'b0, wb_ready;
  logic [4:0]  wb_sel = '0;
  logic [31:0] wb_data = '0;
  logic [4:0]  gpr_select;
  logic        gpr_load;
  logic [31:0] gpr_wdata, gpr_rdata;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  gpr_port_arbiter #(.REG_W(32), .SEL_W(5), .STARVE_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rd_req_valid(rd_req_valid), .o_rd_req_ready(rd_req_ready),
    .i_rs1(rs1), .i_rs2(rs2), .i_need_rs2(need_rs2),
    .o_opnd_valid(opnd_valid), .i_opnd_ready(opnd_ready),
    .o_rs1_data(rs1_data), .o_rs2_data(rs2_data),
    .i_wb_valid(wb_valid), .o_wb_ready(wb_ready),
    .i_wb_sel(wb_sel), .i_wb_data(wb_data),
    .o_gpr_select(gpr_select), .o_gpr_load(gpr_load), .o_gpr_wdata(gpr_wdata),
    .i_gpr_rdata(gpr_rdata), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Single-port register file: combinational read, write at the edge.
  logic [31:0] rf [32];
  assign gpr_rdata = rf[gpr_select];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (gpr_load) begin
      rf[gpr_select] <= gpr_wdata;
    end
  end

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] s, input logic [31:0] d);
    wb_valid = 1'b1; wb_sel = s; wb_data = d;
    to_neg(); to_pos();
    wb_valid = 1'b0;
  endtask

  task automatic accept(input logic [4:0] a, input logic [4:0] b, input logic n);
    rd_req_valid = 1'b1; rs1 = a; rs2 = b; need_rs2 = n;
    to_neg(); to_pos();
    rd_req_valid = 1'b0;
  endtask

  task automatic release_hold();
    opnd_ready = 1'b1;
    to_neg(); to_pos();
    opnd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wb_valid = 1'b1; wb_sel = 5'd3; wb_data = '0; rd_req_valid = 1'b1;
    to_pos(); to_neg();
    n_vec++; if (rd_req_ready !== 1'b0) begin n_err++; $display("FAIL rst_rd_ready got=%b exp=0", rd_req_ready); end
    n_vec++; if (wb_ready !== 1'b0) begin n_err++; $display("FAIL rst_wb_ready got=%b exp=0", wb_ready); end
    n_vec++; if (gpr_load !== 1'b0) begin n_err++; $display("FAIL rst_load got=%b exp=0", gpr_load); end
    n_vec++; if (opnd_valid !== 1'b0) begin n_err++; $display("FAIL rst_opnd_valid got=%b exp=0", opnd_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_vec++; if (rs1_data !== 32'h0) begin n_err++; $display("FAIL rst_rs1 got=%h exp=0", rs1_data); end
    rd_req_valid = 1'b0;
    to_pos(); rst_n = 1'b1; to_neg();
    n_vec++; if (rd_req_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_rd_ready got=%b exp=1", rd_req_ready); end
    n_vec++; if (wb_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_wb_ready got=%b exp=1", wb_ready); end
    to_pos(); wb_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    wb_write(5'd5, 32'h1111_0000);
    wb_write(5'd7, 32'h0000_2222);
    rd_req_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd7; need_rs2 = 1'b1;
    to_neg();
    n_vec++; if (rd_req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got=%b exp=1", rd_req_ready); end
    to_pos(); rd_req_valid = 1'b0; to_neg();
    n_vec++; if (gpr_select !== 5'd5) begin n_err++; $display("FAIL b2b_sel1 got=%0d exp=5", gpr_select); end
    n_vec++; if (opnd_valid !== 1'b0) begin n_err++; $display("FAIL b2b_early1 got=%b exp=0", opnd_valid); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    to_pos(); to_neg();
    n_vec++; if (gpr_select !== 5'd7) begin n_err++; $display("FAIL b2b_sel2 got=%0d exp=7", gpr_select); end
    n_vec++; if (opnd_valid !== 1'b0) begin n_err++; $display("FAIL b2b_early2 got=%b exp=0", opnd_valid); end
    to_pos();
    rd_req_valid = 1'b1; rs1 = 5'd0; rs2 = 5'd0; need_rs2 = 1'b0; opnd_ready = 1'b1;
    to_neg();
    n_vec++; if (opnd_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid got=%b exp=1", opnd_valid); end
    n_vec++; if (rs1_data !== 32'h1111_0000) begin n_err++; $display("FAIL b2b_rs1 got=%h exp=11110000", rs1_data); end
    n_vec++; if (rs2_data !== 32'h0000_2222) begin n_err++; $display("FAIL b2b_rs2 got=%h exp=00002222", rs2_data); end
    n_vec++; if (rd_req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_hold_ready got=%b exp=0", rd_req_ready); end
    to_pos(); to_neg();
    n_vec++; if (rd_req_ready !== 1'b1 || opnd_valid !== 1'b0) begin n_err++; $display("FAIL b2b_bubble got=%b/%b exp=1/0", rd_req_ready, opnd_valid); end
    to_pos(); rd_req_valid = 1'b0; to_neg();
    n_vec++; if (opnd_valid !== 1'b1 || rs1_data !== 32'h0) begin n_err++; $display("FAIL b2b_next got=%b/%h exp=1/0", opnd_valid, rs1_data); end
    to_pos(); opnd_ready = 1'b0;
  endtask

  task automatic test_x0_shortcut();
    accept(5'd0, 5'd0, 1'b1); to_neg();
    n_vec++; if (opnd_valid !== 1'b1) begin n_err++; $display("FAIL x0_valid got=%b exp=1", opnd_valid); end
    n_vec++; if (gpr_select !== 5'd0) begin n_err++; $display("FAIL x0_sel got=%0d exp=0", gpr_select); end
    n_vec++; if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin n_err++; $display("FAIL x0_ops got=%h/%h exp=0/0", rs1_data, rs2_data); end
    to_pos(); release_hold();
    accept(5'd0, 5'd7, 1'b1); to_neg();
    n_vec++; if (opnd_valid !== 1'b0 || gpr_select !== 5'd7) begin n_err++; $display("FAIL x0_rs2_sel got=%b/%0d exp=0/7", opnd_valid, gpr_select); end
    to_pos(); to_neg();
    n_vec++; if (opnd_valid !== 1'b1) begin n_err++; $display("FAIL x0_rs2_valid got=%b exp=1", opnd_valid); end
    n_vec++; if (rs1_data !== 32'h0 || rs2_data !== 32'h0000_2222) begin n_err++; $display("FAIL x0_rs2_ops got=%h/%h exp=0/00002222", rs1_data, rs2_data); end
    to_pos(); release_hold();
  endtask

  task automatic test_wb_preempt();
    accept(5'd3, 5'd0, 1'b0);
    wb_valid = 1'b1; wb_sel = 5'd3; wb_data = 32'hDEAD_BEEF; to_neg();
    n_vec++; if (wb_ready !== 1'b1 || gpr_load !== 1'b1) begin n_err++; $display("FAIL pre_grant got=%b/%b exp=1/1", wb_ready, gpr_load); end
    n_vec++; if (gpr_select !== 5'd3 || gpr_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL pre_port got=%0d/%h exp=3/deadbeef", gpr_select, gpr_wdata); end
    to_pos(); wb_valid = 1'b0; to_neg();
    n_vec++; if (opnd_valid !== 1'b0 || gpr_select !== 5'd3 || gpr_load !== 1'b0) begin n_err++; $display("FAIL pre_hold got=%b/%0d/%b exp=0/3/0", opnd_valid, gpr_select, gpr_load); end
    to_pos(); to_neg();
    n_vec++; if (opnd_valid !== 1'b1 || rs1_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL pre_data got=%b/%h exp=1/deadbeef", opnd_valid, rs1_data); end
    to_pos(); release_hold();
  endtask

  task automatic test_starvation();
    accept(5'd5, 5'd0, 1'b0);
    wb_valid = 1'b1; wb_sel = 5'd9;
    for (int i = 0; i < LIMIT; i++) begin
      wb_data = 32'hA0 + 32'(i); to_neg();
      n_vec++; if (wb_ready !== 1'b1 || gpr_select !== 5'd9) begin n_err++; $display("FAIL starve_grant%0d got=%b/%0d exp=1/9", i, wb_ready, gpr_select); end
      to_pos();
    end
    to_neg();
    n_vec++; if (wb_ready !== 1'b0 || gpr_load !== 1'b0 || gpr_select !== 5'd5) begin n_err++; $display("FAIL starve_block got=%b/%b/%0d exp=0/0/5", wb_ready, gpr_load, gpr_select); end
    to_pos(); to_neg();
    n_vec++; if (wb_ready !== 1'b1 || opnd_valid !== 1'b1) begin n_err++; $display("FAIL starve_resume got=%b/%b exp=1/1", wb_ready, opnd_valid); end
    n_vec++; if (rs1_data !== 32'h1111_0000) begin n_err++; $display("FAIL starve_data got=%h exp=11110000", rs1_data); end
    to_pos(); wb_valid = 1'b0; release_hold();
    accept(5'd9, 5'd0, 1'b0); to_pos(); to_neg();
    n_vec++; if (opnd_valid !== 1'b1 || rs1_data !== 32'hA3) begin n_err++; $display("FAIL starve_x9 got=%b/%h exp=1/000000a3", opnd_valid, rs1_data); end
    to_pos(); release_hold();
  endtask

  task automatic test_x0_write();
    wb_valid = 1'b1; wb_sel = 5'd0; wb_data = 32'hFFFF_FFFF; to_neg();
    n_vec++; if (wb_ready !== 1'b1 || gpr_load !== 1'b0) begin n_err++; $display("FAIL x0wr got=%b/%b exp=1/0", wb_ready, gpr_load); end
    to_pos(); wb_valid = 1'b0;
    accept(5'd0, 5'd0, 1'b0); to_neg();
    n_vec++; if (opnd_valid !== 1'b1 || rs1_data !== 32'h0) begin n_err++; $display("FAIL x0wr_read got=%b/%h exp=1/0", opnd_valid, rs1_data); end
    to_pos(); release_hold();
  endtask

  task automatic test_reset_mid_rd2();
    accept(5'd5, 5'd7, 1'b1); to_pos();
    rst_n = 1'b0; wb_valid = 1'b1; wb_sel = 5'd4; wb_data = 32'h1; to_neg();
    n_vec++; if (wb_ready !== 1'b0 || rd_req_ready !== 1'b0 || gpr_load !== 1'b0) begin n_err++; $display("FAIL rrd2_in got=%b/%b/%b exp=0/0/0", wb_ready, rd_req_ready, gpr_load); end
    to_pos(); rst_n = 1'b1; wb_valid = 1'b0; to_neg();
    n_vec++; if (opnd_valid !== 1'b0 || busy !== 1'b0 || rd_req_ready !== 1'b1) begin n_err++; $display("FAIL rrd2_idle got=%b/%b/%b exp=0/0/1", opnd_valid, busy, rd_req_ready); end
    n_vec++; if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin n_err++; $display("FAIL rrd2_ops got=%h/%h exp=0/0", rs1_data, rs2_data); end
    to_pos(); to_neg();
    n_vec++; if (opnd_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rrd2_stale got=%b/%b exp=0/0", opnd_valid, busy); end
    to_pos();
  endtask

  task automatic test_random();
    logic [31:0] sh [32];
    int          ph;   // 0 waiting for request, 1 reads outstanding, 2 presenting
    int          pq_which[$];
    logic [4:0]  pq_sel[$];
    int          starve;
    logic [31:0] eop1, eop2;
    logic        ewbr, grant, eload;
    logic [4:0]  esel;
    logic [31:0] ewd;
    rst_n = 1'b0; rd_req_valid = 1'b0; wb_valid = 1'b0; opnd_ready = 1'b0;
    to_pos(); rst_n = 1'b1;
    for (int i = 0; i < 32; i++) sh[i] = '0;
    ph = 0; starve = 0; eop1 = '0; eop2 = '0;
    for (int c = 0; c < 600; c++) begin
      rd_req_valid = ($urandom_range(0, 2) == 0);
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      need_rs2 = 1'($urandom_range(0, 1));
      wb_valid = ($urandom_range(0, 3) != 0);
      wb_sel = 5'($urandom_range(0, 7)); wb_data = $urandom;
      opnd_ready = 1'($urandom_range(0, 1));
      ewbr  = !(ph == 1 && starve == LIMIT);
      grant = wb_valid && ewbr;
      esel  = grant ? wb_sel : (ph == 1 ? pq_sel[0] : 5'd0);
      eload = grant && (wb_sel != 5'd0);
      ewd   = grant ? wb_data : 32'h0;
      to_neg();
      n_vec++; if (rd_req_ready !== (ph == 0)) begin n_err++; $display("FAIL rnd_rd_ready c=%0d got=%b exp=%b", c, rd_req_ready, ph == 0); end
      n_vec++; if (wb_ready !== ewbr) begin n_err++; $display("FAIL rnd_wb_ready c=%0d got=%b exp=%b", c, wb_ready, ewbr); end
      n_vec++; if (opnd_valid !== (ph == 2) || busy !== (ph != 0)) begin n_err++; $display("FAIL rnd_state c=%0d got=%b/%b exp=%b/%b", c, opnd_valid, busy, ph == 2, ph != 0); end
      n_vec++; if (gpr_select !== esel || gpr_load !== eload || gpr_wdata !== ewd) begin n_err++; $display("FAIL rnd_port c=%0d got=%0d/%b/%h exp=%0d/%b/%h", c, gpr_select, gpr_load, gpr_wdata, esel, eload, ewd); end
      if (ph == 2) begin
        n_vec++; if (rs1_data !== eop1 || rs2_data !== eop2) begin n_err++; $display("FAIL rnd_ops c=%0d got=%h/%h exp=%h/%h", c, rs1_data, rs2_data, eop1, eop2); end
      end
      case (ph)
        0: if (rd_req_valid) begin
          eop1 = '0; eop2 = '0;
          if (rs1 != 5'd0) begin pq_which.push_back(1); pq_sel.push_back(rs1); end
          if (need_rs2 && rs2 != 5'd0) begin pq_which.push_back(2); pq_sel.push_back(rs2); end
          ph = (pq_sel.size() != 0) ? 1 : 2;
        end
        1: if (grant) starve++;
           else begin
             if (pq_which[0] == 1) eop1 = sh[pq_sel[0]]; else eop2 = sh[pq_sel[0]];
             void'(pq_which.pop_front()); void'(pq_sel.pop_front());
             starve = 0;
             if (pq_sel.size() == 0) ph = 2;
           end
        default: if (opnd_ready) ph = 0;
      endcase
      if (ph != 1) starve = 0;
      if (grant && wb_sel != 5'd0) sh[wb_sel] = wb_data;
      to_pos();
    end
    rd_req_valid = 1'b0; wb_valid = 1'b0; opnd_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_x0_shortcut();
    test_wb_preempt();
    test_starvation();
    test_x0_write();
    test_reset_mid_rd2();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gpr_port_arbiter.md
# gpr_port_arbiter

Sequences and shares the single-port general-purpose register file between the decode stage and the writeback stage. It turns one operand request (rs1, optional rs2) into back-to-back single-port reads, captures the results, and presents both operands together. Writebacks take priority, subject to an anti-starvation limit. It sits between decode/writeback and the register file's `i_select_gpr` / `i_load_gpr` / `i_data_to_load_gpr` / `o_data_at_gpr` port; the PC path does not pass through it.

## Interface
- `REG_W`, 32, data width of a GPR.
- `SEL_W`, 5, GPR select width.
- `STARVE_LIMIT`, 4, maximum consecutive writeback-granted cycles while a read is waiting; must be ≥ 1.

Ports:
- `i_clk`  in  1  clock; everything is updated on the posedge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_rd_req_valid` / `o_rd_req_ready`  in / out  1 / 1  operand request handshake.
- `i_rs1`, `i_rs2`  in  SEL_W each  source register numbers.
- `i_need_rs2`  in  1  when 0, rs2 is not read and its operand is 0.
- `o_opnd_valid` / `i_opnd_ready`  out / in  1 / 1  operand delivery handshake.
- `o_rs1_data`, `o_rs2_data`  out  REG_W each  captured operands.
- `i_wb_valid` / `o_wb_ready`  in / out  1 / 1  writeback handshake.
- `i_wb_sel`  in  SEL_W  destination register.
- `i_wb_data`  in  REG_W  data to write.
- `o_gpr_select`  out  SEL_W  drives the register file select input.
- `o_gpr_load`  out  1  drives the register file load input.
- `o_gpr_wdata`  out  REG_W  drives the register file data input.
- `i_gpr_rdata`  in  REG_W  combinational read data from the register file.
- `o_busy`  out  1  high when the state is not IDLE.

## Operation
- FSM states: IDLE, RD1, RD2, HOLD.
- **IDLE**
  - `o_rd_req_ready` = 1.
  - On `valid & ready`, latch rs1, rs2 and need_rs2.
  - Next state:
    - RD1 if rs1 ≠ 0;
    - else RD2 if need_rs2 and rs2 ≠ 0;
    - else HOLD.
  - Operands whose register is x0, or rs2 when `need_rs2` = 0, are set to 0 at acceptance and use no port cycle.
- **RD1 / RD2**
  - If a writeback is granted this cycle, the port performs the write and the state holds.
  - Otherwise `o_gpr_select` = rs1 (or rs2) and `i_gpr_rdata` is captured into `o_rs1_data` (or `o_rs2_data`) at the edge.
  - RD1 then goes to RD2 if rs2 is needed and ≠ 0; otherwise to HOLD.
  - RD2 always goes to HOLD.
- **HOLD**
  - `o_opnd_valid` = 1; operands are stable.
  - On `i_opnd_ready`, go to IDLE.
- **Writeback grant**
  - `o_wb_ready` = 1 in every cycle except (a) reset is asserted, or (b) the state is RD1/RD2 and `starve_cnt` == STARVE_LIMIT.
  - When granted: `o_gpr_select` = `i_wb_sel`, `o_gpr_wdata` = `i_wb_data`, and `o_gpr_load` = (`i_wb_sel` ≠ 0).
  - A write to x0 is accepted and dropped.
- **starve_cnt**
  - Increments in each RD1/RD2 cycle in which a writeback is granted.
  - Clears when a read is performed, and in every other state.
  - Counter width is $clog2(STARVE_LIMIT+1).
- **Idle port defaults:** select = 0, load = 0, wdata = 0.
- **Ordering:** an operand reflects the register file contents at its capture edge. A writeback granted after the capture does not update the captured value; hazard handling is upstream.

## Timing
- `o_gpr_select`, `o_gpr_load` and `o_gpr_wdata` are combinational from the state, the latched selects and the wb inputs. The register file writes at the same edge.
- `o_rd_req_ready` and `o_wb_ready` are combinational; `o_opnd_valid` is registered (decoded from the state).
- Latency from request acceptance at edge N, with no writebacks:
  - both reads: `o_opnd_valid` in cycle N+3;
  - one read: N+2;
  - zero reads: N+1.
- Each writeback-granted cycle in RD1/RD2 adds 1 cycle.
- HOLD→IDLE costs one bubble: a new request presented with `i_opnd_ready` is accepted one cycle later.
- Reset (any state, including mid-read):
  - state → IDLE, `starve_cnt` = 0, operands = 0;
  - `o_opnd_valid` = 0, `o_busy` = 0, `o_rd_req_ready` = 0, `o_wb_ready` = 0;
  - `o_gpr_load` = 0.
  - A pending request is discarded.

## Test plan
- **Back-to-back reads:** preload x5=0x1111_0000, x7=0x0000_2222; request rs1=5, rs2=7, need_rs2=1 → `o_opnd_valid` at N+3 with 0x1111_0000 / 0x0000_2222; `o_gpr_select` = 5 then 7.
- **x0 shortcuts:** rs1=0, rs2=0, need_rs2=1 → valid at N+1, both operands 0, `o_gpr_select` never leaves 0. Also rs1=0, rs2=7 → valid at N+2.
- **Writeback preemption:** during RD1 (rs1=3), wb x3=0xDEAD_BEEF → write occurs first, state holds, then `o_rs1_data` = 0xDEAD_BEEF.
- **Starvation:** `i_wb_valid` held high with writes to x9 while in RD1 → 4 grants, then `o_wb_ready` = 0 for one cycle and the read proceeds; afterwards grants resume.
- **x0 write:** wb sel=0, data=0xFFFF_FFFF → `o_wb_ready` = 1, `o_gpr_load` = 0; a subsequent read of rs1=0 returns 0.
- **Reset mid-RD2:** deassert `i_rst_n` for 1 cycle → next cycle is IDLE, outputs are at reset values, and no stale `o_opnd_valid` appears.
